// File: rtl/cpu_clk_sync.sv
// -----------------------------------------------------------------------------
// cpu_clk_sync
//   Brings the slow or manually toggled CPU clock level into the sys_clk
//   domain. The CPU datapath is clocked by sys_clk and qualified by the
//   single-cycle enables produced here, instead of by a derived clock.
//   Halt, single-step and resume control gate those enables, and a wrapping
//   counter tallies every cpu_ce pulse issued.
//
// Optional feature macro: CPU_CLK_FALL_EN
//   defined   : clk_fall and cpu_ce_n are generated; a single step runs a full
//               CPU cycle and returns to HALTED on the falling edge.
//   undefined : clk_fall and cpu_ce_n are tied low; a step returns to HALTED
//               on the rising edge.
//
// Ports
//   sys_clk      in   system clock, all logic on its rising edge
//   rst_n        in   asynchronous active-low reset
//   cpu_clk      in   asynchronous CPU clock level
//   halt         in   halt level, only its rising edge acts
//   step         in   single-step request pulse (sys_clk synchronous)
//   resume       in   resume request pulse (sys_clk synchronous)
//   clk_rise     out  one-cycle pulse per cpu_clk rising edge, ungated
//   clk_fall     out  one-cycle pulse per cpu_clk falling edge (optional)
//   cpu_ce       out  gated rising-edge enable to the CPU
//   cpu_ce_n     out  gated falling-edge enable to the CPU (optional)
//   halted       out  high while in HALTED
//   cycle_count  out  number of cpu_ce pulses issued, wraps silently
//
// State | meaning
//   ST_RUN        | enables pass freely
//   ST_HALTED     | all enables blocked, waiting for step or resume
//   ST_STEP       | one rising-edge enable allowed through
//   ST_STEP_ARMED | rise of the step passed, waiting for its fall
//                 | (only reachable with CPU_CLK_FALL_EN)
// -----------------------------------------------------------------------------
module cpu_clk_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             cpu_clk,
  input  logic             halt,
  input  logic             step,
  input  logic             resume,
  output logic             clk_rise,
  output logic             clk_fall,
  output logic             cpu_ce,
  output logic             cpu_ce_n,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_HALTED     = 2'd1,
    ST_STEP       = 2'd2,
    ST_STEP_ARMED = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_last;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_w;
  logic                   halt_q;
  logic                   halt_edge;
  logic [CNT_W-1:0]       cnt_q;
  state_t                 state_q;

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign halt_edge = halt & ~halt_q;

  // Synchroniser chain, previous level and registered rise pulse.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cpu_clk};
      prev_q <= sync_last;
      rise_q <= sync_last & ~prev_q;
      halt_q <= halt;
    end
  end

`ifdef CPU_CLK_FALL_EN
  logic fall_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      fall_q <= 1'b0;
    end else begin
      fall_q <= ~sync_last & prev_q;
    end
  end

  assign fall_w   = fall_q;
  assign cpu_ce_n = fall_q & ((state_q == ST_RUN) | (state_q == ST_STEP_ARMED));
`else
  assign fall_w   = 1'b0;
  assign cpu_ce_n = 1'b0;
`endif

  // Control FSM. Resume wins over everything outside RUN; halt edges are
  // only honoured in RUN so a step in flight always completes.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (halt_edge) state_q <= ST_HALTED;
        end
        ST_HALTED: begin
          if (resume)    state_q <= ST_RUN;
          else if (step) state_q <= ST_STEP;
        end
        ST_STEP: begin
          if (resume) state_q <= ST_RUN;
`ifdef CPU_CLK_FALL_EN
          else if (rise_q) state_q <= ST_STEP_ARMED;
`else
          else if (rise_q) state_q <= ST_HALTED;
`endif
        end
`ifdef CPU_CLK_FALL_EN
        ST_STEP_ARMED: begin
          if (resume)      state_q <= ST_RUN;
          else if (fall_w) state_q <= ST_HALTED;
        end
`endif
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign cpu_ce = rise_q & ((state_q == ST_RUN) | (state_q == ST_STEP));
  assign halted = (state_q == ST_HALTED);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cpu_ce) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign clk_rise    = rise_q;
  assign clk_fall    = fall_w;
  assign cycle_count = cnt_q;

endmodule
